// File: rtl/ps2_kbd_fifo.sv
// ps2_kbd_fifo: Wishbone-slave PS/2 keyboard receiver with keycode FIFO.
// Samples PS2_CLK/PS2_DATA in the clk domain, checks start/parity/stop,
// folds E0 (extended) and F0 (break) prefixes into one entry and queues
// entries for software.
// Optional build macro: PS2_KBD_IRQ_EN enables the level interrupt and the
// RW CTRL[1] irq_en bit; without it irq_o is tied low.
`timescale 1ns/1ps
module ps2_kbd_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        wb_rst_n,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        irq_o
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } rx_state_t;

    // ------------------------------------------------------------------
    // Synchronisers and PS2_CLK falling-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   clk_prev;
    logic                   ps2_fall;
    logic                   ps2_din;

    // Bring the asynchronous PS/2 lines into the clk domain (idle high)
    always_ff @(posedge clk) begin
        if (!wb_rst_n) begin
            clk_sync <= '1;
            dat_sync <= '1;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], PS2_CLK};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], PS2_DATA};
            clk_prev <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign ps2_fall = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign ps2_din  = dat_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    rx_state_t     state;
    rx_state_t     state_nxt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          par_ok;
    logic          frame_ok;
    logic          perr_evt;
    logic          ferr_evt;
    logic          rx_en;

    assign timeout = (state != S_IDLE) && !ps2_fall && (to_cnt >= TO_LAST);
    assign par_ok  = ^{shreg, par_bit};

    // State register
    always_ff @(posedge clk) begin
        if (!wb_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: advance one step per PS2_CLK falling edge
    always_comb begin
        state_nxt = state;
        if (!rx_en || timeout) begin
            state_nxt = S_IDLE;
        end else if (ps2_fall) begin
            case (state)
                S_IDLE:   if (!ps2_din) state_nxt = S_DATA;
                S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
                S_PARITY: state_nxt = S_STOP;
                S_STOP:   state_nxt = S_IDLE;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    // Frame outcome decode, valid on the stop-bit edge or on timeout
    always_comb begin
        frame_ok = 1'b0;
        perr_evt = 1'b0;
        ferr_evt = 1'b0;
        if (rx_en) begin
            if (state == S_STOP && ps2_fall) begin
                frame_ok = ps2_din & par_ok;
                perr_evt = ~par_ok;
                ferr_evt = ~ps2_din;
            end
            if (timeout) begin
                ferr_evt = 1'b1;
            end
        end
    end

    // Receiver datapath: shift register, bit counter, inactivity counter
    always_ff @(posedge clk) begin
        if (!wb_rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            to_cnt  <= '0;
        end else begin
            if (ps2_fall || state == S_IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt < TO_LAST) begin
                to_cnt <= to_cnt + 1'b1;
            end
            if (ps2_fall) begin
                case (state)
                    S_IDLE:   bit_cnt <= '0;
                    S_DATA: begin
                        shreg   <= {ps2_din, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    S_PARITY: par_bit <= ps2_din;
                    default:  ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Prefix folding
    // ------------------------------------------------------------------
    logic       ext;
    logic       rel;
    logic       push_req;
    logic [9:0] push_data;

    assign push_req  = frame_ok && (shreg != 8'hE0) && (shreg != 8'hF0);
    assign push_data = {rel, ext, shreg};

    // Track E0/F0 prefixes until a real code (or an error) consumes them
    always_ff @(posedge clk) begin
        if (!wb_rst_n) begin
            ext <= 1'b0;
            rel <= 1'b0;
        end else if (perr_evt || ferr_evt) begin
            ext <= 1'b0;
            rel <= 1'b0;
        end else if (frame_ok) begin
            if (shreg == 8'hE0) begin
                ext <= 1'b1;
            end else if (shreg == 8'hF0) begin
                rel <= 1'b1;
            end else begin
                ext <= 1'b0;
                rel <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Wishbone decode
    // ------------------------------------------------------------------
    logic       bus_req;
    logic       bus_rd;
    logic       bus_wr;
    logic [1:0] reg_sel;

    // ~wb_ack_o forces a dead cycle so each access gets exactly one ack
    assign bus_req = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign bus_rd  = bus_req & ~wb_we_i;
    assign bus_wr  = bus_req &  wb_we_i;
    assign reg_sel = wb_adr_i[3:2];

    // ------------------------------------------------------------------
    // Keycode FIFO
    // ------------------------------------------------------------------
    logic [9:0]    mem [0:FIFO_DEPTH-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          flush;
    logic          pop;
    logic          push_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign flush   = bus_wr && (reg_sel == 2'd2) && wb_dat_i[2];
    assign pop     = bus_rd && (reg_sel == 2'd0) && !empty;
    assign push_ok = push_req && !full && !flush;

    // Entry storage
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; flush wins over a concurrent push
    always_ff @(posedge clk) begin
        if (!wb_rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky status flags and control register
    // ------------------------------------------------------------------
    logic ovf;
    logic perr;
    logic ferr;
    logic status_wr;
    logic ctrl_wr;
    logic irq_en_rd;

    assign status_wr = bus_wr && (reg_sel == 2'd1);
    assign ctrl_wr   = bus_wr && (reg_sel == 2'd2);

    // Sticky flags: a hardware set in the same cycle beats a W1C
    always_ff @(posedge clk) begin
        if (!wb_rst_n) begin
            ovf  <= 1'b0;
            perr <= 1'b0;
            ferr <= 1'b0;
        end else begin
            ovf  <= (push_req && full && !flush) | (ovf  & ~(status_wr & wb_dat_i[2]));
            perr <= perr_evt                     | (perr & ~(status_wr & wb_dat_i[3]));
            ferr <= ferr_evt                     | (ferr & ~(status_wr & wb_dat_i[4]));
        end
    end

    // Receiver enable
    always_ff @(posedge clk) begin
        if (!wb_rst_n) begin
            rx_en <= 1'b1;
        end else if (ctrl_wr) begin
            rx_en <= wb_dat_i[0];
        end
    end

`ifdef PS2_KBD_IRQ_EN
    logic irq_en;
    logic irq_r;

    // Interrupt enable and registered level interrupt (lags FIFO by a cycle)
    always_ff @(posedge clk) begin
        if (!wb_rst_n) begin
            irq_en <= 1'b0;
            irq_r  <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= wb_dat_i[1];
            irq_r <= irq_en & ~empty;
        end
    end

    assign irq_en_rd = irq_en;
    assign irq_o     = irq_r;
`else
    assign irq_en_rd = 1'b0;
    assign irq_o     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read mux and bus response
    // ------------------------------------------------------------------
    logic [31:0] rdata;
    logic [7:0]  count_b;

    assign count_b = 8'(count);

    // Select register contents for the current read
    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0:    rdata = empty ? 32'h0 : {1'b1, 21'h0, mem[rd_ptr]};
            2'd1:    rdata = {16'h0, count_b, 3'b000, ferr, perr, ovf, full, empty};
            2'd2:    rdata = {29'h0, 1'b0, irq_en_rd, rx_en};
            default: rdata = '0;
        endcase
    end

    // Registered acknowledge and read data
    always_ff @(posedge clk) begin
        if (!wb_rst_n) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            wb_ack_o <= bus_req;
            wb_dat_o <= bus_rd ? rdata : 32'h0;
        end
    end

    assign wb_err_o = 1'b0;

    logic unused_bits;
`ifdef PS2_KBD_IRQ_EN
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:5]};
`else
    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:5], wb_dat_i[1]};
`endif

endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Self-checking bench for ps2_kbd_fifo: directed scenarios plus a randomized
// frame stream checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_ps2_kbd_fifo;

    localparam int DEPTH = 8;
    localparam int TMO   = 300;
    localparam int HALF  = 10;

    logic        clk = 1'b0;
    logic        wb_rst_n = 1'b0;
    logic        PS2_CLK = 1'b1;
    logic        PS2_DATA = 1'b1;
    logic        wb_cyc_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_we_i = 1'b0;
    logic [31:0] wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [3:0]  wb_sel_i = 4'hF;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        irq_o;

    ps2_kbd_fifo #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(TMO),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .wb_rst_n(wb_rst_n), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [9:0] mq[$];
    bit m_ext, m_rel, m_ovf, m_perr, m_ferr;

    function automatic void model_reset();
        mq.delete();
        m_ext = 0; m_rel = 0; m_ovf = 0; m_perr = 0; m_ferr = 0;
    endfunction

    function automatic void model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        if (bad_par || bad_stop) begin
            if (bad_par)  m_perr = 1;
            if (bad_stop) m_ferr = 1;
            m_ext = 0; m_rel = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_rel = 1;
        end else begin
            if (mq.size() == DEPTH) m_ovf = 1;
            else mq.push_back({m_rel, m_ext, b});
            m_ext = 0; m_rel = 0;
        end
    endfunction

    function automatic logic [31:0] model_status();
        logic [7:0] c;
        c = 8'(mq.size());
        return {16'h0, c, 3'b000, m_ferr, m_perr, m_ovf, mq.size() == DEPTH, mq.size() == 0};
    endfunction

    function automatic logic [31:0] model_pop();
        logic [9:0] e;
        if (mq.size() == 0) return 32'h0;
        e = mq.pop_front();
        return {1'b1, 21'h0, e};
    endfunction

    // Drive the first nbits of a frame: start, 8 data LSB first, parity, stop
    task automatic ps2_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2_DATA = fr[i];
            repeat (HALF) @(posedge clk);
            PS2_CLK = 1'b0;
            repeat (HALF) @(posedge clk);
            PS2_CLK = 1'b1;
        end
        PS2_DATA = 1'b1;
        repeat (HALF) @(posedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        ps2_bits(b, bad_par, bad_stop, 11);
        model_frame(b, bad_par, bad_stop);
        repeat (10) @(posedge clk);
    endtask

    task automatic wb_xfer(input logic [31:0] adr, input bit we, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        bit got;
        got = 0;
        rdat = 'x;
        @(posedge clk); #1;
        wb_adr_i = adr; wb_we_i = we; wb_dat_i = wdat;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge clk); #1;
            if (wb_ack_o) begin
                got = 1;
                rdat = wb_dat_o;
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL wb_ack adr=%h got=no_ack exp=ack", adr);
        end
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
        wb_xfer(adr, 1'b0, 32'h0, d);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] v);
        logic [31:0] d;
        wb_xfer(adr, 1'b1, v, d);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        wb_rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", wb_ack_o); end
        checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat got=%h exp=0", wb_dat_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
        checks++; if (wb_err_o !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", wb_err_o); end
        wb_rst_n = 1'b1;
        model_reset();
        wb_read(32'h4, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_status got=%h exp=00000001", d); end
        wb_read(32'h8, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL reset_ctrl got=%h exp=00000001", d); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d, e;
        ps2_bits(8'h33, 0, 0, 5);
        @(posedge clk); #1;
        wb_rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 wb_rst_n = 1'b1;
        model_reset();
        send_frame(8'h5A, 0, 0);
        wb_read(32'h4, d);
        e = model_status();
        checks++; if (d !== e) begin errors++; $display("FAIL midreset_status got=%h exp=%h", d, e); end
        wb_read(32'h0, d);
        e = model_pop();
        checks++; if (d !== e) begin errors++; $display("FAIL midreset_data got=%h exp=%h", d, e); end
    endtask

    task automatic test_single();
        logic [31:0] d;
        send_frame(8'h1C, 0, 0);
        wb_read(32'h4, d);
        checks++; if (d !== 32'h00000100) begin errors++; $display("FAIL single_status got=%h exp=00000100", d); end
        wb_read(32'h0, d); void'(model_pop());
        checks++; if (d !== 32'h8000001C) begin errors++; $display("FAIL single_data got=%h exp=8000001c", d); end
        wb_read(32'h0, d); void'(model_pop());
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL single_empty got=%h exp=00000000", d); end
    endtask

    task automatic test_prefix();
        logic [31:0] d;
        send_frame(8'hE0, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h75, 0, 0);
        wb_read(32'h0, d); void'(model_pop());
        checks++; if (d !== 32'h80000375) begin errors++; $display("FAIL prefix_data got=%h exp=80000375", d); end
        wb_read(32'h4, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL prefix_status got=%h exp=00000001", d); end
    endtask

    task automatic test_parity();
        logic [31:0] d;
        send_frame(8'h1C, 1, 0);
        wb_read(32'h4, d);
        checks++; if (d !== 32'h9) begin errors++; $display("FAIL parity_status got=%h exp=00000009", d); end
        wb_write(32'h4, 32'h8); m_perr = 0;
        wb_read(32'h4, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL parity_w1c got=%h exp=00000001", d); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        for (int i = 0; i < 9; i++) send_frame(8'h16 + 8'(i), 0, 0);
        wb_read(32'h4, d);
        checks++; if (d !== 32'h806) begin errors++; $display("FAIL ovf_status got=%h exp=00000806", d); end
        for (int i = 0; i < 8; i++) begin
            wb_read(32'h0, d); void'(model_pop());
            checks++;
            if (d !== (32'h80000016 + 32'(i))) begin
                errors++; $display("FAIL ovf_data%0d got=%h exp=%h", i, d, 32'h80000016 + 32'(i));
            end
        end
        wb_write(32'h4, 32'h4); m_ovf = 0;
        wb_read(32'h4, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL ovf_w1c got=%h exp=00000001", d); end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        ps2_bits(8'h55, 0, 0, 5);
        repeat (TMO + 10) @(posedge clk);
        m_ferr = 1; m_ext = 0; m_rel = 0;
        wb_read(32'h4, d);
        checks++; if (d !== 32'h11) begin errors++; $display("FAIL timeout_status got=%h exp=00000011", d); end
        send_frame(8'h29, 0, 0);
        wb_read(32'h0, d); void'(model_pop());
        checks++; if (d !== 32'h80000029) begin errors++; $display("FAIL timeout_next got=%h exp=80000029", d); end
        wb_write(32'h4, 32'h10); m_ferr = 0;
        wb_read(32'h4, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL timeout_w1c got=%h exp=00000001", d); end
    endtask

    task automatic test_back_to_back();
        int acks;
        logic [31:0] e;
        acks = 0;
        e = model_status();
        @(posedge clk); #1;
        wb_adr_i = 32'h4; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (wb_ack_o) begin
                acks++;
                checks++;
                if (wb_dat_o !== e) begin errors++; $display("FAIL b2b_data got=%h exp=%h", wb_dat_o, e); end
            end
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        checks++; if (acks !== 3) begin errors++; $display("FAIL b2b_acks got=%0d exp=3", acks); end
    endtask

    task automatic test_rx_disable();
        logic [31:0] d, e;
        wb_write(32'h8, 32'h0);
        ps2_bits(8'h1C, 0, 0, 11);
        repeat (10) @(posedge clk);
        wb_read(32'h4, d);
        e = model_status();
        checks++; if (d !== e) begin errors++; $display("FAIL rxdis_status got=%h exp=%h", d, e); end
        wb_write(32'h8, 32'h1);
    endtask

    task automatic test_irq();
        logic [31:0] d, e;
`ifdef PS2_KBD_IRQ_EN
        wb_write(32'h8, 32'h3);
        wb_read(32'h8, d);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL irq_ctrl got=%h exp=00000003", d); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_idle got=%b exp=0", irq_o); end
        send_frame(8'h1C, 0, 0);
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", irq_o); end
        wb_read(32'h0, d); e = model_pop();
        checks++; if (d !== e) begin errors++; $display("FAIL irq_data got=%h exp=%h", d, e); end
        repeat (2) @(posedge clk); #1;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_drop got=%b exp=0", irq_o); end
        send_frame(8'h1C, 0, 0);
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_rise2 got=%b exp=1", irq_o); end
        wb_write(32'h8, 32'h4); mq.delete();
        repeat (2) @(posedge clk); #1;
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_flush got=%b exp=0", irq_o); end
`else
        wb_write(32'h8, 32'h3);
        wb_read(32'h8, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL irq_ctrl_ro got=%h exp=00000001", d); end
        send_frame(8'h1C, 0, 0);
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_tied got=%b exp=0", irq_o); end
        wb_write(32'h8, 32'h5); mq.delete();
`endif
        wb_read(32'h4, d);
        e = model_status();
        checks++; if (d !== e) begin errors++; $display("FAIL flush_status got=%h exp=%h", d, e); end
        wb_write(32'h8, 32'h1);
    endtask

    task automatic test_random();
        logic [31:0] d, e;
        logic [7:0]  b;
        int r, k;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else            b = 8'($urandom_range(0, 255));
            k = $urandom_range(0, 11);
            send_frame(b, k == 0, k == 1);
            if ($urandom_range(0, 2) == 0) begin
                wb_read(32'h0, d); e = model_pop();
                checks++; if (d !== e) begin errors++; $display("FAIL rand_data i=%0d got=%h exp=%h", i, d, e); end
            end
            if (i % 10 == 9) begin
                wb_read(32'h4, d); e = model_status();
                checks++; if (d !== e) begin errors++; $display("FAIL rand_status i=%0d got=%h exp=%h", i, d, e); end
            end
        end
        for (int i = 0; i <= DEPTH; i++) begin
            wb_read(32'h0, d); e = model_pop();
            checks++; if (d !== e) begin errors++; $display("FAIL rand_drain i=%0d got=%h exp=%h", i, d, e); end
        end
        wb_write(32'h4, 32'h1C);
        m_ovf = 0; m_perr = 0; m_ferr = 0;
        wb_read(32'h4, d); e = model_status();
        checks++; if (d !== e) begin errors++; $display("FAIL rand_final got=%h exp=%h", d, e); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_prefix();
        test_parity();
        test_overflow();
        test_timeout();
        test_back_to_back();
        test_rx_disable();
        test_irq();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_fifo.md
Name: ps2_kbd_fifo

Overview:
Wishbone-slave PS/2 keyboard receiver, successor to the single-register keyboard peripheral.
- Samples PS2_CLK/PS2_DATA in the system clock domain and checks start, odd-parity and stop bits.
- Folds E0 (extended) and F0 (break) prefixes into one decoded entry and queues entries in a parametrised FIFO.
- Software reads the FIFO through a four-register Wishbone window. Sits on the SweRVolf peripheral bus next to the other memory-mapped I/O.

Parameters:
FIFO_DEPTH, 8, entries in the keycode FIFO; power of two, 2..128.
TIMEOUT_CYCLES, 50000, clk cycles with no PS2_CLK falling edge before a partial frame is aborted.
SYNC_STAGES, 2, flip-flop stages on PS2_CLK and PS2_DATA; minimum 2.

Ports:
clk  in  1  system clock; all logic on posedge.
wb_rst_n  in  1  synchronous, active-low reset.
PS2_CLK  in  1  keyboard clock, asynchronous.
PS2_DATA  in  1  keyboard data, asynchronous.
wb_cyc_i  in  1  bus cycle valid.
wb_stb_i  in  1  strobe.
wb_we_i  in  1  write enable.
wb_adr_i  in  32  byte address; bits [3:2] select the register.
wb_dat_i  in  32  write data.
wb_sel_i  in  4  byte selects; ignored, all writes are full-word.
wb_dat_o  out  32  registered read data.
wb_ack_o  out  1  transfer acknowledge.
wb_err_o  out  1  always 0.
irq_o  out  1  level interrupt, FIFO not empty.

Behaviour:
- Reset (wb_rst_n=0 at posedge clk):
  - FIFO empty; all sticky flags 0; CTRL=0x1 (rx enabled, irq disabled); receiver in IDLE with prefix flags cleared.
  - wb_ack_o=0, wb_dat_o=0, irq_o=0.
  - Reset asserted mid-frame discards the partial frame.
- Sync and edge detect: SYNC_STAGES flops on each PS2 line. A PS2_CLK falling edge is detected as synced value 1 followed by 0. Data is sampled on that edge.
- Receiver FSM:
  - IDLE: on an edge with data=0 go to DATA (bit count 0). An edge with data=1 is ignored.
  - DATA: shift in 8 bits, LSB first. After the 8th bit go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: stop=1 and odd parity over data+parity → frame complete. Parity bad → set PERR. Stop=0 → set FERR. Return to IDLE in all cases.
  - Timeout: a counter resets on each edge. In any state other than IDLE, reaching TIMEOUT_CYCLES sets FERR and returns to IDLE.
  - CTRL.rx_en=0: FSM held in IDLE, no pushes.
- Decode on frame complete:
  - Byte 0xE0 sets ext. Byte 0xF0 sets rel. Neither pushes.
  - Any other byte pushes entry {bit9=rel, bit8=ext, bits7:0=byte}, then clears ext and rel.
  - A parity, frame or timeout error clears ext and rel.
- FIFO:
  - A push when full is dropped and sets OVF.
  - Push and pop in the same cycle both take effect; count is unchanged. A push and a pop on an empty FIFO in the same cycle: the read returns 0 and the push lands.
  - Flush has priority over a push in the same cycle.
- Wishbone access:
  - wb_ack_o pulses 1 cycle after wb_cyc_i & wb_stb_i, then returns to 0 for at least one cycle; one ack per access. wb_dat_o is valid with the ack.
  - A pop occurs only on the acknowledged read of DATA.
- Register map:
  - 0x0 DATA (RO, pop): [31]=1 when an entry is returned, [9] rel, [8] ext, [7:0] code. Reads 0x00000000 when empty, no pop.
  - 0x4 STATUS: [0] empty, [1] full, [2] OVF, [3] PERR, [4] FERR, [15:8] count. Write 1 to bits 2..4 clears them (W1C).
  - 0x8 CTRL (RW): [0] rx_en, [1] irq_en. Bit [2] is write-1 flush and reads 0.
  - 0xC: reads 0; writes ignored.
  - Writes to DATA are ignored.
- Sticky flags (OVF, PERR, FERR): hardware set has priority over a W1C in the same cycle.

Optional Feature:
PS2_KBD_IRQ_EN
- Defined: irq_o = CTRL.irq_en & ~empty, registered, so it lags the FIFO state by one cycle. CTRL[1] is RW.
- Undefined: irq_o is tied to 0, CTRL[1] is read-only 0, and the irq logic is absent.

Test Plan:
- Frame 0x1C (start 0, bits LSB first, parity 0, stop 1) → STATUS count=1; DATA read returns 0x8000001C; the next DATA read returns 0x00000000.
- Frames E0, F0, 75 → a single entry; DATA read returns 0x80000375; count returns to 0.
- Frame 0x1C with parity 1 → no entry; STATUS=0x00000009 (empty, PERR). Write 0x8 to STATUS → PERR cleared.
- Nine frames 0x16..0x1E with FIFO_DEPTH=8 → STATUS full=1, OVF=1, count=8. Eight reads return 0x80000016..0x8000001D.
- Five bits of a frame, then PS2_CLK idle for TIMEOUT_CYCLES+10 → FERR=1, no entry; a following good frame 0x29 yields 0x80000029.
- With PS2_KBD_IRQ_EN defined, CTRL=0x3, send 0x1C → irq_o rises within 2 cycles of the push; a DATA read drops it. Write 0x4 to CTRL with an entry pending → FIFO empties and irq_o=0.
